// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the data-memory write path.
//   - size codes used on the store and dmem sides
//   - the store-buffer entry record {addr, wdata, size}
//   - small helpers for word addressing and size decoding
// The entry record uses ADDR_W/DATA_W. Any instance of store_buffer must
// keep its AW/DW equal to these values.
package rv_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        size;
    } entry_t;

    // Word (32-bit) address of a byte address.
    function automatic logic [ADDR_W-3:0] word_addr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2];
    endfunction

    // Size code 11 is treated as a full word, the same as 10.
    function automatic logic is_word(input logic [1:0] sz);
        return (sz == SIZE_W) || (sz == 2'b11);
    endfunction

endpackage

// File: rtl/stbuf_match.sv
// stbuf_match: combinational load-vs-pending-store comparator.
// Ports:
//   i_valid      per-entry valid bits
//   i_word_addr  per-entry word address (byte address >> 2)
//   i_ld_word    word address of the load
//   o_conflict   some valid entry holds the load's word
//   With STBUF_FWD_EN defined:
//   i_wr_ptr     next write slot; the slot just behind it is the youngest
//   i_word_ok    per-entry flag: aligned full-word store
//   o_young_idx  slot of the youngest matching entry
//   o_young_word youngest matching entry is an aligned full-word store
module stbuf_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic [DEPTH-1:0]           i_valid,
    input  logic [DEPTH-1:0][AW-3:0]   i_word_addr,
    input  logic [AW-3:0]              i_ld_word,
`ifdef STBUF_FWD_EN
    input  logic [$clog2(DEPTH)-1:0]   i_wr_ptr,
    input  logic [DEPTH-1:0]           i_word_ok,
    output logic [$clog2(DEPTH)-1:0]   o_young_idx,
    output logic                       o_young_word,
`endif
    output logic                       o_conflict
);

    logic [DEPTH-1:0] w_hit;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output
        // a value before any conditional code, so no latch can be inferred.
        w_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit[i] = i_valid[i] && (i_word_addr[i] == i_ld_word);
        end
    end

    assign o_conflict = |w_hit;

`ifdef STBUF_FWD_EN
    localparam int PW = $clog2(DEPTH);

    // Walk from the oldest possible slot (wr_ptr - DEPTH == wr_ptr) to the
    // youngest (wr_ptr - 1); the last hit seen is the youngest match.
    always_comb begin
        logic [PW-1:0] w_idx;
        o_young_idx  = '0;
        o_young_word = 1'b0;
        w_idx        = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_wr_ptr - PW'(k);
            if (w_hit[w_idx]) begin
                o_young_idx  = w_idx;
                o_young_word = i_word_ok[w_idx];
            end
        end
    end
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the pipeline M stage and the
// dmem write port. Accepts one store per cycle, drains in strict FIFO order
// one per cycle while dmem is ready, and flags loads that hit a pending word.
// Reset is synchronous, active low.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   s_we/s_addr/s_wdata/s_size      store request from the M stage
//   s_full                          buffer full, M stage must hold the store
//   ld_re/ld_addr                   load in the M stage
//   ld_stall                        load hits a pending store
//   m_we/m_addr/m_wdata/m_size      head entry towards dmem
//   m_ready                         dmem takes the head this cycle
//   empty                           no pending stores
// Optional macro STBUF_FWD_EN adds ld_fwd/ld_fwd_data: a load whose youngest
// match is an aligned word store is served from the buffer instead of stalled.
module store_buffer
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_we,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    input  logic [1:0]    s_size,
    output logic          s_full,
    input  logic          ld_re,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_stall,
`ifdef STBUF_FWD_EN
    output logic          ld_fwd,
    output logic [DW-1:0] ld_fwd_data,
`endif
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [1:0]    m_size,
    input  logic          m_ready,
    output logic          empty
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [PW:0]             r_count;
    logic [DEPTH-1:0]        r_valid;
    entry_t [DEPTH-1:0]      r_mem;

    logic                    w_push;
    logic                    w_pop;
    entry_t                  w_head;
    logic [DEPTH-1:0][AW-3:0] w_word_addr;
    logic                    w_conflict;
    logic                    w_unused_ld_ofs;

    // A push is refused whenever the buffer is full, even if the head drains
    // in the same cycle.
    assign s_full = (r_count == FULL_CNT);
    assign m_we   = (r_count != '0);
    assign empty  = !m_we;
    assign w_push = s_we && !s_full;
    assign w_pop  = m_we && m_ready;

    // Head fields are forced to zero while empty so the never-written
    // storage array cannot leak onto the dmem port.
    assign w_head  = r_mem[r_rd_ptr];
    assign m_addr  = m_we ? w_head.addr  : '0;
    assign m_wdata = m_we ? w_head.wdata : '0;
    assign m_size  = m_we ? w_head.size  : '0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; every read of it is qualified by
    // a valid bit or by count, which keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: s_addr, wdata: s_wdata, size: s_size};
        end
    end

    always_comb begin
        w_word_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_word_addr[i] = word_addr(r_mem[i].addr);
        end
    end

    // Conflicts are word granular; the load's byte offset plays no part.
    assign w_unused_ld_ofs = ^ld_addr[1:0];

`ifdef STBUF_FWD_EN
    logic [DEPTH-1:0] w_word_ok;
    logic [PW-1:0]    w_young_idx;
    logic             w_young_word;

    always_comb begin
        w_word_ok = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_word_ok[i] = is_word(r_mem[i].size) && (r_mem[i].addr[1:0] == 2'b00);
        end
    end

    stbuf_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
        .i_valid      (r_valid),
        .i_word_addr  (w_word_addr),
        .i_ld_word    (ld_addr[AW-1:2]),
        .i_wr_ptr     (r_wr_ptr),
        .i_word_ok    (w_word_ok),
        .o_young_idx  (w_young_idx),
        .o_young_word (w_young_word),
        .o_conflict   (w_conflict)
    );

    assign ld_fwd      = ld_re && w_conflict && w_young_word;
    assign ld_stall    = ld_re && w_conflict && !w_young_word;
    assign ld_fwd_data = ld_fwd ? r_mem[w_young_idx].wdata : '0;
`else
    stbuf_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
        .i_valid     (r_valid),
        .i_word_addr (w_word_addr),
        .i_ld_word   (ld_addr[AW-1:2]),
        .o_conflict  (w_conflict)
    );

    assign ld_stall = ld_re && w_conflict;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test-plan steps followed by a random phase,
// all checked against a queue-based model of the buffer.
module tb_store_buffer;
    import rv_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [1:0]    s_size;
    logic          s_full;
    logic          ld_re;
    logic [AW-1:0] ld_addr;
    logic          ld_stall;
`ifdef STBUF_FWD_EN
    logic          ld_fwd;
    logic [DW-1:0] ld_fwd_data;
`endif
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_size;
    logic          m_ready;
    logic          empty;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_size     (s_size),
        .s_full     (s_full),
        .ld_re      (ld_re),
        .ld_addr    (ld_addr),
        .ld_stall   (ld_stall),
`ifdef STBUF_FWD_EN
        .ld_fwd     (ld_fwd),
        .ld_fwd_data(ld_fwd_data),
`endif
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_size     (m_size),
        .m_ready    (m_ready),
        .empty      (empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } st_t;

    st_t q[$];          // pending stores, oldest first
    int  n_checks = 0;
    int  n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the queue: head is q[0], youngest match is the
    // last matching element.
    task automatic check_outputs(input string tag);
        bit  hit = 0;
        bit  fwd_ok;
        st_t y = '{default: '0};
        bit  nonempty = (q.size() != 0);
        foreach (q[i]) begin
            if (q[i].addr[31:2] == ld_addr[31:2]) begin
                hit = 1;
                y   = q[i];
            end
        end
        fwd_ok = ld_re && hit && y.size[1] && (y.addr[1:0] == 2'b00);
        check({tag, ".s_full"},  s_full,  64'(q.size() == DEPTH));
        check({tag, ".m_we"},    m_we,    64'(nonempty));
        check({tag, ".empty"},   empty,   64'(!nonempty));
        check({tag, ".m_addr"},  m_addr,  nonempty ? 64'(q[0].addr) : 64'd0);
        check({tag, ".m_wdata"}, m_wdata, nonempty ? 64'(q[0].data) : 64'd0);
        check({tag, ".m_size"},  m_size,  nonempty ? 64'(q[0].size) : 64'd0);
`ifdef STBUF_FWD_EN
        check({tag, ".ld_fwd"},      ld_fwd,      64'(fwd_ok));
        check({tag, ".ld_fwd_data"}, ld_fwd_data, fwd_ok ? 64'(y.data) : 64'd0);
        check({tag, ".ld_stall"},    ld_stall,    64'(ld_re && hit && !fwd_ok));
`else
        if (fwd_ok) y.size = y.size;
        check({tag, ".ld_stall"},    ld_stall,    64'(ld_re && hit));
`endif
    endtask

    // Check the current cycle, then advance one clock and update the model.
    task automatic tick(input string tag);
        bit  push, pop;
        st_t e;
        #1;
        check_outputs(tag);
        push = s_we && (q.size() < DEPTH);
        pop  = (q.size() != 0) && m_ready;
        e    = '{addr: s_addr, data: s_wdata, size: s_size};
        @(posedge clk);
        if (!reset) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic rdy);
        s_we = we; s_addr = a; s_wdata = d; s_size = sz; m_ready = rdy;
    endtask

    initial begin
        reset = 1'b0; ld_re = 1'b0; ld_addr = '0;
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        tick("reset");
        reset = 1'b1;

        // Single store, one-cycle latency, then drained.
        drive(1, 32'h100, 32'hDEADBEEF, SIZE_W, 1);
        tick("single_push");
        drive(0, 0, 0, 0, 1);
        check("single.m_addr", m_addr, 64'h100);
        check("single.m_wdata", m_wdata, 64'hDEADBEEF);
        tick("single_head");
        check("single.empty", empty, 64'd1);
        tick("single_done");

        // Fill with dmem stalled; fifth push is refused; drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 32'hA000_0000 + 32'(i), SIZE_W, 0);
            tick("fill");
        end
        check("fill.s_full", s_full, 64'd1);
        drive(1, 32'h10, 32'hBAD0_0010, SIZE_W, 0);
        tick("fill_reject");
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1 check("drain.m_addr", m_addr, 64'(i * 4));
            tick("drain");
        end
        check("drain.empty", empty, 64'd1);
        tick("drain_done");

        // Full plus simultaneous push and pop: pop only, three remain.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h40 + 32'(i * 4), 32'(i), SIZE_W, 0);
            tick("refill");
        end
        drive(1, 32'h80, 32'h80, SIZE_W, 1);
        tick("full_pushpop");
        drive(0, 0, 0, 0, 0);
        check("pushpop.s_full", s_full, 64'd0);
        check("pushpop.m_addr", m_addr, 64'h44);
        tick("after_pushpop");
        drive(0, 0, 0, 0, 1);
        repeat (3) tick("drain3");
        check("drain3.empty", empty, 64'd1);

        // Byte store at 0x203 blocks a load of word 0x200 but not 0x204.
        drive(1, 32'h203, 32'h55, SIZE_B, 0);
        tick("byte_push");
        drive(0, 0, 0, 0, 0);
        ld_re = 1; ld_addr = 32'h200;
        #1 check("byte.ld_stall_200", ld_stall, 64'd1);
        tick("ld_200");
        ld_addr = 32'h204;
        #1 check("byte.ld_stall_204", ld_stall, 64'd0);
        tick("ld_204");
        ld_re = 0;
        drive(0, 0, 0, 0, 1);
        tick("byte_drain");

        // Two word stores to 0x300: youngest data is forwarded.
        drive(1, 32'h300, 32'h11111111, SIZE_W, 0);
        tick("fwd_push1");
        drive(1, 32'h300, 32'h22222222, SIZE_W, 0);
        tick("fwd_push2");
        drive(0, 0, 0, 0, 0);
        ld_re = 1; ld_addr = 32'h300;
        #1;
`ifdef STBUF_FWD_EN
        check("fwd.ld_fwd", ld_fwd, 64'd1);
        check("fwd.ld_fwd_data", ld_fwd_data, 64'h22222222);
        check("fwd.ld_stall", ld_stall, 64'd0);
`else
        check("fwd.ld_stall", ld_stall, 64'd1);
`endif
        tick("fwd_load");
        ld_re = 0;

        // Reset with three pending: all discarded, next store drains.
        drive(1, 32'h500, 32'h5, SIZE_H, 0);
        tick("pre_reset");
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick("mid_reset");
        reset = 1'b1;
        check("rst.m_we", m_we, 64'd0);
        check("rst.empty", empty, 64'd1);
        check("rst.s_full", s_full, 64'd0);
        drive(1, 32'h600, 32'h600, SIZE_W, 1);
        tick("post_reset_push");
        drive(0, 0, 0, 0, 1);
        check("post.m_addr", m_addr, 64'h600);
        tick("post_reset_drain");

        // Random traffic over a small address window to provoke matches.
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 99) != 0);
            s_we    = $urandom_range(0, 1) == 1;
            s_addr  = 32'h400 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3) * ($urandom_range(0, 2) == 0));
            s_wdata = $urandom;
            s_size  = 2'($urandom_range(0, 3));
            m_ready = $urandom_range(0, 9) < 6;
            ld_re   = $urandom_range(0, 1) == 1;
            ld_addr = 32'h400 + 32'($urandom_range(0, 27));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
